// File: rtl/hit_rate_monitor.sv
// Counts rising edges of the pattern-detector strobe over fixed back-to-back windows and raises a level IRQ on threshold.
// Optional lifetime event counter is built when HIT_RATE_MON_TOTAL_EN is defined; otherwise total_count_o is tied to 0.
module hit_rate_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             hit_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             irq_ack_i,
    output logic [CNT_W-1:0] win_count_o,
    output logic [CNT_W-1:0] last_count_o,
    output logic             win_done_o,
    output logic             irq_o,
    output logic [CNT_W-1:0] total_count_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALERT = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    state_e           state_q, state_d;
    logic             hit_q;
    logic [CNT_W-1:0] win_count_q, win_count_d;
    logic [CNT_W-1:0] last_count_q, last_count_d;
    logic [WIN_W-1:0] win_cyc_q, win_cyc_d;
    logic             win_done_q, win_done_d;
    logic             irq_q, irq_d;
    logic             armed_q, armed_d;

    logic             event_s;
    logic             active_s;
    logic             close_s;
    logic             fire_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // Event detection, window-close and threshold-fire qualifiers
    always_comb begin
        event_s   = hit_i & ~hit_q;
        active_s  = en_i & ((state_q == ST_RUN) | (state_q == ST_ALERT));
        cnt_inc_s = sat_inc(win_count_q, event_s);
        if (win_len_i != WIN_ZERO) begin
            close_s = active_s & (win_cyc_q == (win_len_i - WIN_ONE));
        end else begin
            close_s = 1'b0;
        end
        // Crossings while already in ALERT are ignored, so firing is RUN-only
        fire_s = active_s & (state_q == ST_RUN) & armed_q &
                 (thresh_i != CNT_ZERO) & (cnt_inc_s >= thresh_i);
    end

    // FSM next-state; dropping en_i overrides both fire and acknowledge
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (fire_s) begin
                    state_d = ST_ALERT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ALERT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (irq_ack_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ALERT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Window counters, completed-window capture and re-arm; close wins over fire on armed
    always_comb begin
        win_count_d  = win_count_q;
        win_cyc_d    = win_cyc_q;
        last_count_d = last_count_q;
        win_done_d   = 1'b0;
        armed_d      = armed_q;
        if (active_s) begin
            if (close_s) begin
                win_count_d  = CNT_ZERO;
                win_cyc_d    = WIN_ZERO;
                last_count_d = cnt_inc_s;
                win_done_d   = 1'b1;
                armed_d      = 1'b1;
            end else begin
                win_count_d  = cnt_inc_s;
                win_done_d   = 1'b0;
                last_count_d = last_count_q;
                if (win_len_i != WIN_ZERO) begin
                    win_cyc_d = win_cyc_q + WIN_ONE;
                end else begin
                    win_cyc_d = win_cyc_q;
                end
                if (fire_s) begin
                    armed_d = 1'b0;
                end else begin
                    armed_d = armed_q;
                end
            end
        end else begin
            win_count_d  = CNT_ZERO;
            win_cyc_d    = WIN_ZERO;
            last_count_d = last_count_q;
            win_done_d   = 1'b0;
            armed_d      = 1'b1;
        end
        irq_d = (state_d == ST_ALERT);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hit_q        <= 1'b0;
            win_count_q  <= CNT_ZERO;
            last_count_q <= CNT_ZERO;
            win_cyc_q    <= WIN_ZERO;
            win_done_q   <= 1'b0;
            irq_q        <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            hit_q        <= hit_i;
            win_count_q  <= win_count_d;
            last_count_q <= last_count_d;
            win_cyc_q    <= win_cyc_d;
            win_done_q   <= win_done_d;
            irq_q        <= irq_d;
            armed_q      <= armed_d;
        end
    end

    assign win_count_o  = win_count_q;
    assign last_count_o = last_count_q;
    assign win_done_o   = win_done_q;
    assign irq_o        = irq_q;

`ifdef HIT_RATE_MON_TOTAL_EN
    logic [CNT_W-1:0] total_q, total_d;

    // Lifetime event count, cleared only by reset
    always_comb begin
        if (active_s) begin
            total_d = sat_inc(total_q, event_s);
        end else begin
            total_d = total_q;
        end
    end

    // Lifetime counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= CNT_ZERO;
        end else begin
            total_q <= total_d;
        end
    end

    assign total_count_o = total_q;
`else
    assign total_count_o = CNT_ZERO;
`endif

endmodule

// File: tb/tb_hit_rate_monitor.sv
// Directed bench for hit_rate_monitor: completed-window counts go through a scoreboard queue
// checked on every win_done pulse; point checks cover irq, win_count, total_count and reset.
module tb_hit_rate_monitor;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;

`ifdef HIT_RATE_MON_TOTAL_EN
    localparam bit TOT_EN = 1'b1;
`else
    localparam bit TOT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             hit = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic [CNT_W-1:0] thresh = '0;
    logic             irq_ack = 1'b0;
    logic [CNT_W-1:0] win_count;
    logic [CNT_W-1:0] last_count;
    logic             win_done;
    logic             irq;
    logic [CNT_W-1:0] total_count;

    int n_checks = 0;
    int n_fail = 0;
    logic [CNT_W-1:0] sb_q[$];
    logic [CNT_W-1:0] mon_exp;

    hit_rate_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .hit_i        (hit),
        .win_len_i    (win_len),
        .thresh_i     (thresh),
        .irq_ack_i    (irq_ack),
        .win_count_o  (win_count),
        .last_count_o (last_count),
        .win_done_o   (win_done),
        .irq_o        (irq),
        .total_count_o(total_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every window close must match the oldest expected count
    always @(negedge clk) begin
        if (rst_n && win_done) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL win_done_unexpected: got last_count %0d, expected no window close", last_count);
            end else begin
                mon_exp = sb_q.pop_front();
                if (last_count !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_last_count: got %0d, expected %0d", last_count, mon_exp);
                end
            end
        end
    end

    initial begin
        bit seen;

        // Reset values
        rst_n = 1'b0;
        tick(3);
        check("rst_win_count", int'(win_count), 0);
        check("rst_last_count", int'(last_count), 0);
        check("rst_win_done", int'(win_done), 0);
        check("rst_irq", int'(irq), 0);
        check("rst_total", int'(total_count), 0);
        rst_n = 1'b1;
        tick(2);

        // Test 1: win_len=10, thresh=0, pulses in RUN cycles 1,3,5
        win_len = 16'd10; thresh = 8'd0; en = 1'b1;
        tick(1);                                  // RUN cycle 0
        check("t1_start_count", int'(win_count), 0);
        tick(1);                                  // cycle 1
        hit = 1'b1; tick(1); hit = 1'b0;          // cycle 2
        check("t1_count_one", int'(win_count), 1);
        tick(1); hit = 1'b1; tick(1); hit = 1'b0; // cycle 4
        tick(1); hit = 1'b1; tick(1); hit = 1'b0; // cycle 6
        check("t1_count_three", int'(win_count), 3);
        sb_q.push_back(8'd3);
        tick(3);                                  // cycle 9, closing cycle
        check("t1_done_not_early", int'(win_done), 0);
        tick(1);                                  // cycle 10
        check("t1_done_pulse", int'(win_done), 1);
        check("t1_count_cleared", int'(win_count), 0);
        check("t1_irq_never", int'(irq), 0);
        tick(1);
        check("t1_done_one_cycle", int'(win_done), 0);
        en = 1'b0; win_len = 16'd0;
        tick(2);
        check("t1_last_retained", int'(last_count), 3);

        // Test 2: thresh=2, pulses at 1 and 4, ack at 8, third pulse at 9
        thresh = 8'd2; win_len = 16'd10; en = 1'b1;
        tick(1);                                  // RUN cycle 0
        tick(1); hit = 1'b1; tick(1); hit = 1'b0; // cycle 2
        tick(2);                                  // cycle 4
        hit = 1'b1;
        check("t2_irq_before_fire", int'(irq), 0);
        tick(1); hit = 1'b0;                      // cycle 5
        check("t2_irq_fire", int'(irq), 1);
        tick(2);                                  // cycle 7
        check("t2_irq_held", int'(irq), 1);
        tick(1); irq_ack = 1'b1;                  // cycle 8
        tick(1); irq_ack = 1'b0;                  // cycle 9
        check("t2_irq_acked", int'(irq), 0);
        hit = 1'b1;
        sb_q.push_back(8'd3);
        tick(1); hit = 1'b0;                      // cycle 10
        check("t2_no_refire", int'(irq), 0);
        check("t2_done_pulse", int'(win_done), 1);
        check("t2_count_cleared", int'(win_count), 0);
        en = 1'b0; win_len = 16'd0; thresh = 8'd0;
        tick(2);

        // Test 3: hit held 20 cycles, win_len=0
        en = 1'b1;
        tick(1);
        hit = 1'b1;
        tick(20);
        check("t3_held_counts_once", int'(win_count), 1);
        check("t3_no_done", int'(win_done), 0);
        hit = 1'b0;
        tick(1);
        en = 1'b0;
        tick(2);
        check("t3_total", int'(total_count), TOT_EN ? 7 : 0);

        // Test 4: 300 pulses in one 650-cycle window saturate at 255
        win_len = 16'd650; en = 1'b1;
        tick(1);
        for (int i = 0; i < 300; i++) begin
            hit = 1'b1; tick(1);
            hit = 1'b0; tick(1);
        end
        check("t4_win_sat", int'(win_count), 255);
        check("t4_total_sat", int'(total_count), TOT_EN ? 255 : 0);
        sb_q.push_back(8'd255);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick(1);
            if (win_done) seen = 1'b1;
        end
        check("t4_close_seen", int'(seen), 1);
        check("t4_last_sat", int'(last_count), 255);
        check("t4_count_cleared", int'(win_count), 0);
        en = 1'b0; win_len = 16'd0;
        tick(2);

        // Test 5: pulse on closing cycle with thresh=1, then re-armed fire, then en drop in ALERT
        thresh = 8'd1; win_len = 16'd4; en = 1'b1;
        tick(1);                                  // RUN cycle 0
        tick(3); hit = 1'b1;                      // cycle 3, closing cycle
        sb_q.push_back(8'd1);
        tick(1); hit = 1'b0;                      // cycle 4
        check("t5_done_pulse", int'(win_done), 1);
        check("t5_last_incl", int'(last_count), 1);
        check("t5_irq_rise", int'(irq), 1);
        check("t5_count_cleared", int'(win_count), 0);
        irq_ack = 1'b1;
        tick(1); irq_ack = 1'b0;                  // cycle 5
        check("t5_irq_acked", int'(irq), 0);
        hit = 1'b1;
        tick(1); hit = 1'b0;                      // cycle 6
        check("t5_rearmed_fire", int'(irq), 1);
        check("t5_count_new_win", int'(win_count), 1);
        en = 1'b0;
        tick(1);                                  // IDLE
        check("t6_irq_cleared", int'(irq), 0);
        check("t6_count_cleared", int'(win_count), 0);
        check("t6_last_kept", int'(last_count), 1);

        // Test 6: asynchronous reset mid-window
        win_len = 16'd10; thresh = 8'd1; en = 1'b1;
        tick(1);
        hit = 1'b1; tick(1); hit = 1'b0;
        tick(1);
        check("t6_pre_irq", int'(irq), 1);
        check("t6_pre_count", int'(win_count), 1);
        rst_n = 1'b0; en = 1'b0;
        #1;
        check("t6_async_win_count", int'(win_count), 0);
        check("t6_async_last", int'(last_count), 0);
        check("t6_async_irq", int'(irq), 0);
        check("t6_async_done", int'(win_done), 0);
        check("t6_async_total", int'(total_count), 0);
        tick(2);
        rst_n = 1'b1;
        tick(15);
        check("t6_post_count", int'(win_count), 0);
        check("t6_post_irq", int'(irq), 0);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
